// File: rtl/memory_game_ctrl_pkg.sv
// Shared types and helpers for the pairs-game turn sequencer.
// Holds the FSM state encoding, label width, reserved tile codes and onehot().
package memory_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PICK1,
        PICK2,
        COMPARE,
        MATCH,
        SHOW,
        DONE
    } state_t;

    localparam int LABEL_W = 4;

    // Codes the tile cells display themselves; real labels never use them.
    localparam logic [LABEL_W-1:0] HIDDEN    = 4'b0000;
    localparam logic [LABEL_W-1:0] ON_CURSOR = 4'b1111;

    function automatic logic [31:0] onehot(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/memory_game_ctrl_timer.sv
// cycle_timer: loadable down-counter used for the show delay and turn limit.
// Ports: clk, rst (async low), i_load/i_val load, i_en count, o_done.
module cycle_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_en,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_en && r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    // Fires on the last counted cycle so the owner reacts on that edge.
    assign o_done = i_en && (r_cnt <= W'(1));

endmodule

// File: rtl/memory_game_ctrl.sv
// Turn sequencer for the two-player pairs game: cursor, selects, compare,
// clear pulses, scores and turn timeout. All outputs are registered.
// Ports: clk, rst (async low), start, btn_move, btn_sel, labels in;
//        cursor_oh, sel_oh, clr_oh, player, score0/1, game_over, timeout out.
module memory_game_ctrl
    import memory_pkg::*;
#(
    parameter int N_TILES     = 16,
    parameter int LABEL_W     = memory_pkg::LABEL_W,
    parameter int SHOW_CYCLES = 50_000_000,
    parameter int TURN_CYCLES = 500_000_000,
    parameter int SCORE_W     = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       btn_move,
    input  logic                       btn_sel,
    input  logic [N_TILES*LABEL_W-1:0] labels,
    output logic [N_TILES-1:0]         cursor_oh,
    output logic [N_TILES-1:0]         sel_oh,
    output logic [N_TILES-1:0]         clr_oh,
    output logic                       player,
    output logic [SCORE_W-1:0]         score0,
    output logic [SCORE_W-1:0]         score1,
    output logic                       game_over,
    output logic                       timeout
);

    localparam logic [SCORE_W-1:0] PAIRS = SCORE_W'(N_TILES / 2);

    function automatic logic [N_TILES-1:0] tile_oh(input logic [4:0] idx);
        return N_TILES'(onehot(idx));
    endfunction

    // First unmatched tile after cur, wrapping; cur itself is tried last.
    function automatic logic [4:0] next_free(
        input logic [4:0]         cur,
        input logic [N_TILES-1:0] m
    );
        logic [4:0] nxt;
        logic       found;
        int         j;
        nxt   = cur;
        found = 1'b0;
        for (int k = 1; k <= N_TILES; k++) begin
            j = int'(cur) + k;
            if (j >= N_TILES) j = j - N_TILES;
            if (!found && (m & tile_oh(5'(j))) == '0) begin
                nxt   = 5'(j);
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

    state_t               r_state, w_next;
    logic [4:0]           r_cur, r_idx1, r_idx2;
    logic [4:0]           w_cur, w_idx1, w_idx2;
    logic [N_TILES-1:0]   r_matched, w_matched;
    logic [N_TILES-1:0]   r_cursor_oh, w_cursor_oh;
    logic [N_TILES-1:0]   r_sel_oh, w_sel_oh;
    logic [N_TILES-1:0]   r_clr_oh, w_clr_oh;
    logic                 r_player, w_player;
    logic [SCORE_W-1:0]   r_score0, w_score0;
    logic [SCORE_W-1:0]   r_score1, w_score1;
    logic                 r_game_over, w_game_over;
    logic                 r_timeout, w_timeout;

    logic [LABEL_W-1:0]   w_lab1, w_lab2;
    logic                 w_free, w_sel_ok1, w_sel_ok2, w_move;
    logic                 w_in_pick, w_show_done, w_turn_done, w_turn_load;

    assign w_lab1 = LABEL_W'(labels >> (LABEL_W * int'(r_idx1)));
    assign w_lab2 = LABEL_W'(labels >> (LABEL_W * int'(r_idx2)));

    assign w_free    = (r_matched & tile_oh(r_cur)) == '0;
    assign w_sel_ok1 = btn_sel && w_free;
    assign w_sel_ok2 = btn_sel && w_free && (r_cur != r_idx1);
    // A select press always swallows a simultaneous move.
    assign w_move    = btn_move && !btn_sel;
    assign w_in_pick = (r_state == PICK1) || (r_state == PICK2);

    // Turn clock restarts on every fresh PICK1, including after a timeout.
    assign w_turn_load = (w_next == PICK1)
                      && ((r_state != PICK1) || w_turn_done);

    // COMPARE counts as the first visible cycle of the show delay.
    cycle_timer #(.W(32)) u_show (
        .clk    (clk),
        .rst    (rst),
        .i_load (r_state == COMPARE),
        .i_val  (32'(SHOW_CYCLES - 1)),
        .i_en   (r_state == SHOW),
        .o_done (w_show_done)
    );

    cycle_timer #(.W(32)) u_turn (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_turn_load),
        .i_val  (32'(TURN_CYCLES)),
        .i_en   (w_in_pick),
        .o_done (w_turn_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = PICK1;
            PICK1: begin
                if (w_turn_done)    w_next = PICK1;
                else if (w_sel_ok1) w_next = PICK2;
            end
            PICK2: begin
                if (w_turn_done)    w_next = PICK1;
                else if (w_sel_ok2) w_next = COMPARE;
            end
            COMPARE: w_next = (w_lab1 == w_lab2) ? MATCH : SHOW;
            MATCH: begin
                if (int'(r_score0) + int'(r_score1) + 1 == N_TILES / 2)
                    w_next = DONE;
                else
                    w_next = PICK1;
            end
            SHOW:    if (w_show_done) w_next = PICK1;
            DONE:    if (start) w_next = PICK1;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_cur       = r_cur;
        w_idx1      = r_idx1;
        w_idx2      = r_idx2;
        w_matched   = r_matched;
        w_sel_oh    = '0;
        w_clr_oh    = '0;
        w_player    = r_player;
        w_score0    = r_score0;
        w_score1    = r_score1;
        w_timeout   = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_cur     = '0;
                    w_matched = '0;
                    w_player  = 1'b0;
                    w_score0  = '0;
                    w_score1  = '0;
                end
            end
            PICK1: begin
                if (w_turn_done) begin
                    w_timeout = 1'b1;
                    w_player  = ~r_player;
                end else if (w_sel_ok1) begin
                    w_idx1   = r_cur;
                    w_sel_oh = tile_oh(r_cur);
                end else if (w_move) begin
                    w_cur = next_free(r_cur, r_matched);
                end
            end
            PICK2: begin
                if (w_turn_done) begin
                    w_timeout = 1'b1;
                    w_player  = ~r_player;
                    w_clr_oh  = tile_oh(r_idx1);
                end else if (w_sel_ok2) begin
                    w_idx2   = r_cur;
                    w_sel_oh = tile_oh(r_cur);
                end else if (w_move) begin
                    w_cur = next_free(r_cur, r_matched);
                end
            end
            MATCH: begin
                w_matched = r_matched | tile_oh(r_idx1) | tile_oh(r_idx2);
                if (!r_player) begin
                    if (r_score0 < PAIRS) w_score0 = r_score0 + SCORE_W'(1);
                end else begin
                    if (r_score1 < PAIRS) w_score1 = r_score1 + SCORE_W'(1);
                end
            end
            SHOW: begin
                if (w_show_done) begin
                    w_clr_oh = tile_oh(r_idx1) | tile_oh(r_idx2);
                    w_player = ~r_player;
                end
            end
            default: ;
        endcase
        // Never park the cursor on a solved tile when a turn begins.
        if (w_next == PICK1 && (w_matched & tile_oh(w_cur)) != '0)
            w_cur = next_free(w_cur, w_matched);
        w_cursor_oh = (w_next == PICK1 || w_next == PICK2)
                    ? tile_oh(w_cur) : '0;
        w_game_over = (w_next == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur       <= '0;
            r_idx1      <= '0;
            r_idx2      <= '0;
            r_matched   <= '0;
            r_cursor_oh <= '0;
            r_sel_oh    <= '0;
            r_clr_oh    <= '0;
            r_player    <= 1'b0;
            r_score0    <= '0;
            r_score1    <= '0;
            r_game_over <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_cur       <= w_cur;
            r_idx1      <= w_idx1;
            r_idx2      <= w_idx2;
            r_matched   <= w_matched;
            r_cursor_oh <= w_cursor_oh;
            r_sel_oh    <= w_sel_oh;
            r_clr_oh    <= w_clr_oh;
            r_player    <= w_player;
            r_score0    <= w_score0;
            r_score1    <= w_score1;
            r_game_over <= w_game_over;
            r_timeout   <= w_timeout;
        end
    end

    assign cursor_oh = r_cursor_oh;
    assign sel_oh    = r_sel_oh;
    assign clr_oh    = r_clr_oh;
    assign player    = r_player;
    assign score0    = r_score0;
    assign score1    = r_score1;
    assign game_over = r_game_over;
    assign timeout   = r_timeout;

    a_score_cap: assert property (@(posedge clk) disable iff (!rst)
        (int'(r_score0) + int'(r_score1)) <= N_TILES / 2);

    a_label_legal: assert property (@(posedge clk) disable iff (!rst)
        (r_state == COMPARE) |->
            (w_lab1 != HIDDEN && w_lab1 != ON_CURSOR
             && w_lab2 != HIDDEN && w_lab2 != ON_CURSOR));

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl with 4 tiles labelled {1,2,1,2}.
// Show delay 3 cycles, turn limit 20 cycles.
module tb_memory_game_ctrl;

    localparam int N  = 4;
    localparam int LW = 4;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          btn_move = 1'b0;
    logic          btn_sel = 1'b0;
    logic [N*LW-1:0] labels = 16'h2121;
    logic [N-1:0]  cursor_oh, sel_oh, clr_oh;
    logic          player, game_over, timeout;
    logic [SW-1:0] score0, score1;

    int n_checks = 0;
    int n_fail   = 0;

    memory_game_ctrl #(
        .N_TILES     (N),
        .LABEL_W     (LW),
        .SHOW_CYCLES (3),
        .TURN_CYCLES (20),
        .SCORE_W     (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .btn_move  (btn_move),
        .btn_sel   (btn_sel),
        .labels    (labels),
        .cursor_oh (cursor_oh),
        .sel_oh    (sel_oh),
        .clr_oh    (clr_oh),
        .player    (player),
        .score0    (score0),
        .score1    (score1),
        .game_over (game_over),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_sel();
        btn_sel = 1'b1; tick(); btn_sel = 1'b0;
    endtask

    task automatic press_move();
        btn_move = 1'b1; tick(); btn_move = 1'b0;
    endtask

    task automatic press_both();
        btn_sel = 1'b1; btn_move = 1'b1; tick();
        btn_sel = 1'b0; btn_move = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({cursor_oh, sel_oh, clr_oh, player, score0, score1,
             game_over, timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b/%b/%b p%b s%0d/%0d g%b t%b want all 0",
                     cursor_oh, sel_oh, clr_oh, player, score0, score1,
                     game_over, timeout);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (cursor_oh !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_cursor: got %b want 0000", cursor_oh);
        end
    endtask

    task automatic test_start_move();
        press_start();
        n_checks++;
        if (cursor_oh !== 4'b0001 || player !== 1'b0
            || score0 !== 5'd0 || score1 !== 5'd0) begin
            n_fail++;
            $display("FAIL start: got cur %b p%b s%0d/%0d want 0001 p0 s0/0",
                     cursor_oh, player, score0, score1);
        end
        press_move();
        n_checks++;
        if (cursor_oh !== 4'b0010) begin
            n_fail++;
            $display("FAIL move1: got %b want 0010", cursor_oh);
        end
        press_move();
        n_checks++;
        if (cursor_oh !== 4'b0100) begin
            n_fail++;
            $display("FAIL move2: got %b want 0100", cursor_oh);
        end
    endtask

    task automatic test_sel_move_same_cycle();
        press_both();
        n_checks++;
        if (sel_oh !== 4'b0100 || cursor_oh !== 4'b0100) begin
            n_fail++;
            $display("FAIL sel_and_move: got sel %b cur %b want 0100 0100",
                     sel_oh, cursor_oh);
        end
        press_sel();
        n_checks++;
        if (sel_oh !== 4'b0000 || cursor_oh !== 4'b0100) begin
            n_fail++;
            $display("FAIL sel_idx1_ignored: got sel %b cur %b want 0000 0100",
                     sel_oh, cursor_oh);
        end
    endtask

    task automatic test_match();
        press_move();
        press_move();
        n_checks++;
        if (cursor_oh !== 4'b0001) begin
            n_fail++;
            $display("FAIL cursor_wrap: got %b want 0001", cursor_oh);
        end
        press_sel();
        n_checks++;
        if (sel_oh !== 4'b0001 || cursor_oh !== 4'b0000) begin
            n_fail++;
            $display("FAIL match_sel2: got sel %b cur %b want 0001 0000",
                     sel_oh, cursor_oh);
        end
        tick();
        tick();
        n_checks++;
        if (score0 !== 5'd1 || player !== 1'b0 || clr_oh !== 4'b0000) begin
            n_fail++;
            $display("FAIL match_score: got s0=%0d p%b clr %b want 1 p0 0000",
                     score0, player, clr_oh);
        end
        n_checks++;
        if (cursor_oh !== 4'b0010) begin
            n_fail++;
            $display("FAIL match_cursor_skip: got %b want 0010", cursor_oh);
        end
    endtask

    task automatic test_full_game();
        press_sel();
        n_checks++;
        if (sel_oh !== 4'b0010) begin
            n_fail++;
            $display("FAIL last_sel1: got %b want 0010", sel_oh);
        end
        press_move();
        n_checks++;
        if (cursor_oh !== 4'b1000) begin
            n_fail++;
            $display("FAIL move_skip_matched: got %b want 1000", cursor_oh);
        end
        press_sel();
        tick();
        tick();
        n_checks++;
        if (game_over !== 1'b1 || score0 !== 5'd2 || score1 !== 5'd0
            || cursor_oh !== 4'b0000) begin
            n_fail++;
            $display("FAIL game_over: got g%b s%0d/%0d cur %b want g1 s2/0 0000",
                     game_over, score0, score1, cursor_oh);
        end
        press_move();
        press_sel();
        n_checks++;
        if (sel_oh !== 4'b0000 || cursor_oh !== 4'b0000
            || game_over !== 1'b1 || score0 !== 5'd2) begin
            n_fail++;
            $display("FAIL done_hold: got sel %b cur %b g%b s0=%0d want 0 0 1 2",
                     sel_oh, cursor_oh, game_over, score0);
        end
        press_start();
        n_checks++;
        if (game_over !== 1'b0 || score0 !== 5'd0 || score1 !== 5'd0
            || cursor_oh !== 4'b0001 || player !== 1'b0) begin
            n_fail++;
            $display("FAIL restart: got g%b s%0d/%0d cur %b p%b want 0 0/0 0001 0",
                     game_over, score0, score1, cursor_oh, player);
        end
    endtask

    task automatic test_mismatch();
        press_move();
        press_sel();
        n_checks++;
        if (sel_oh !== 4'b0010) begin
            n_fail++;
            $display("FAIL mis_sel1: got %b want 0010", sel_oh);
        end
        press_move();
        press_sel();
        n_checks++;
        if (sel_oh !== 4'b0100) begin
            n_fail++;
            $display("FAIL mis_sel2: got %b want 0100", sel_oh);
        end
        tick();
        tick();
        n_checks++;
        if (clr_oh !== 4'b0000 || player !== 1'b0) begin
            n_fail++;
            $display("FAIL show_early: got clr %b p%b want 0000 p0",
                     clr_oh, player);
        end
        tick();
        n_checks++;
        if (clr_oh !== 4'b0110 || player !== 1'b1) begin
            n_fail++;
            $display("FAIL show_clear: got clr %b p%b want 0110 p1",
                     clr_oh, player);
        end
        n_checks++;
        if (cursor_oh !== 4'b0100 || score0 !== 5'd0 || score1 !== 5'd0) begin
            n_fail++;
            $display("FAIL after_show: got cur %b s%0d/%0d want 0100 0/0",
                     cursor_oh, score0, score1);
        end
        tick();
        n_checks++;
        if (clr_oh !== 4'b0000) begin
            n_fail++;
            $display("FAIL clr_one_cycle: got %b want 0000", clr_oh);
        end
    endtask

    task automatic test_reset_mid_show();
        logic saw;
        press_sel();
        press_move();
        press_sel();
        n_checks++;
        if (sel_oh !== 4'b1000) begin
            n_fail++;
            $display("FAIL p1_sel2: got %b want 1000", sel_oh);
        end
        tick();
        n_checks++;
        if (player !== 1'b1) begin
            n_fail++;
            $display("FAIL p1_turn: got player %b want 1", player);
        end
        rst = 1'b0;
        #2;
        n_checks++;
        if ({cursor_oh, sel_oh, clr_oh, player, score0, score1,
             game_over, timeout} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got cur %b clr %b p%b want all 0",
                     cursor_oh, clr_oh, player);
        end
        tick();
        tick();
        rst = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            tick();
            if (clr_oh !== 4'b0000 || cursor_oh !== 4'b0000) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: got activity %b want 0", saw);
        end
    endtask

    task automatic test_timeout();
        int waited;
        press_start();
        press_move();
        press_sel();
        n_checks++;
        if (sel_oh !== 4'b0010) begin
            n_fail++;
            $display("FAIL to_sel1: got %b want 0010", sel_oh);
        end
        waited = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (timeout === 1'b1) begin
                waited = k;
                break;
            end
        end
        n_checks++;
        if (waited != 18) begin
            n_fail++;
            $display("FAIL pick2_timeout_time: got %0d cycles want 18", waited);
        end
        n_checks++;
        if (clr_oh !== 4'b0010 || player !== 1'b1 || cursor_oh !== 4'b0010) begin
            n_fail++;
            $display("FAIL pick2_timeout: got clr %b p%b cur %b want 0010 1 0010",
                     clr_oh, player, cursor_oh);
        end
        tick();
        n_checks++;
        if (timeout !== 1'b0 || clr_oh !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_pulse: got t%b clr %b want 0 0000",
                     timeout, clr_oh);
        end
        repeat (18) tick();
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL pick1_timeout_early: got %b want 0", timeout);
        end
        press_sel();
        n_checks++;
        if (timeout !== 1'b1 || sel_oh !== 4'b0000
            || clr_oh !== 4'b0000 || player !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_beats_sel: got t%b sel %b clr %b p%b want 1 0 0 0",
                     timeout, sel_oh, clr_oh, player);
        end
    endtask

    initial begin
        test_reset();
        test_start_move();
        test_sel_move_same_cycle();
        test_match();
        test_full_game();
        test_mismatch();
        test_reset_mid_show();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
